button_keypad_decoder: RTL



---
 rtl/button_keypad_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/button_keypad_decoder.sv
// button_keypad_decoder: synchronises, debounces and priority-encodes push-buttons
// into a key index with a one-cycle strobe, plus optional auto-repeat of a held key.
module button_keypad_decoder #(
   parameter int N_BTN        = 8,
   parameter int IDX_W        = 3,
   parameter int DEBOUNCE_CYC = 4,
   parameter int REPEAT_DELAY = 0,
   parameter int REPEAT_RATE  = 4,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn,
   input  logic             repeat_en,
   output logic [IDX_W-1:0] key_idx,
   output logic             key_valid,
   output logic             key_held,
   output logic             key_multi,
   output logic [N_BTN-1:0] btn_state
);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW = $clog2(RMAX + 1);
   localparam logic [N_BTN-1:0] REL = ACTIVE_LOW != 0 ? '1 : '0;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [TW-1:0] DLY_LAST = REPEAT_DELAY > 0 ? TW'(REPEAT_DELAY - 1) : '0;
   localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);
   localparam bit RPT_ON = REPEAT_DELAY > 0;

   typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;

   logic [N_BTN-1:0] sync1, sync2, synced, deb, press;
   logic [IDX_W-1:0] hi, idx_d;
   logic [TW-1:0]    timer, timer_d;
   logic             any, strobe;
   state_t           state, state_d;

   // reset parks the synchronisers at the released level so a held key re-strobes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1 <= REL;
         sync2 <= REL;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end

   assign synced = ACTIVE_LOW != 0 ? ~sync2 : sync2;

   for (genvar i = 0; i < N_BTN; i++) begin : g_deb
      logic [CW-1:0] cnt;
      logic          d;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            cnt <= '0;
            d   <= 1'b0;
         end else if (synced[i] == d) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            cnt <= '0;
            d   <= synced[i];
         end else begin
            cnt <= cnt + 1'b1;
         end
      assign deb[i] = d;
   end

   // btn_state is the previous debounced vector, so it doubles as the edge reference
   assign press = deb & ~btn_state;
   assign any   = |press;

   always_comb begin
      hi = '0;
      for (int i = 0; i < N_BTN; i++)
         if (press[i]) hi = IDX_W'(i);
   end

   always_comb begin
      state_d = state;
      idx_d   = key_idx;
      strobe  = 1'b0;
      timer_d = timer == '1 ? timer : timer + 1'b1;
      case (state)
         IDLE: begin
            timer_d = '0;
            if (any) begin
               idx_d   = hi;
               strobe  = 1'b1;
               state_d = HELD;
            end
         end
         HELD:
            if (!deb[key_idx]) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (any) begin
               idx_d   = hi;
               strobe  = 1'b1;
               timer_d = '0;
            end else if (RPT_ON && repeat_en && timer == DLY_LAST) begin
               strobe  = 1'b1;
               timer_d = '0;
               state_d = RPT;
            end
         RPT:
            if (!deb[key_idx]) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (any) begin
               idx_d   = hi;
               strobe  = 1'b1;
               timer_d = '0;
               state_d = HELD;
            end else if (!repeat_en) begin
               timer_d = '0;
               state_d = HELD;
            end else if (timer == RATE_LAST) begin
               strobe  = 1'b1;
               timer_d = '0;
            end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         key_idx   <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         key_multi <= 1'b0;
         btn_state <= '0;
      end else begin
         state     <= state_d;
         timer     <= timer_d;
         key_idx   <= idx_d;
         key_valid <= strobe;
         key_held  <= deb[idx_d];
         key_multi <= (deb & (deb - 1'b1)) != '0;
         btn_state <= deb;
      end
endmodule
